// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter
// Two-requester round-robin arbiter for a single shared external bus.
// Arbitration takes one cycle: a request seen in IDLE becomes the owner of
// the bus on the next cycle. The owner's request is forwarded combinationally.
// The external ack and read data come back to the owner in the same cycle.
// Optional feature macro: EXT_ARB_TIMEOUT_EN. It enables a watchdog that
// aborts a granted transaction after TIMEOUT_CYCLES unacknowledged cycles.
// The watchdog then pulses the owner's err output.
module ext_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic [15:0] i_m0_addr,
  input  logic        i_m0_stb,
  input  logic [3:0]  i_m0_we,
  input  logic [31:0] i_m0_dat_w,
  output logic        o_m0_ack,
  output logic [31:0] o_m0_dat_r,
  output logic        o_m0_err,

  input  logic [15:0] i_m1_addr,
  input  logic        i_m1_stb,
  input  logic [3:0]  i_m1_we,
  input  logic [31:0] i_m1_dat_w,
  output logic        o_m1_ack,
  output logic [31:0] o_m1_dat_r,
  output logic        o_m1_err,

  output logic [15:0] o_ext_addr,
  output logic        o_ext_stb,
  output logic [3:0]  o_ext_we,
  output logic [31:0] o_ext_dat_w,
  input  logic        i_ext_ack,
  input  logic [31:0] i_ext_dat_r,

  output logic [1:0]  o_grant
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // The watchdog compares against a 16-bit limit, so the parameter is narrowed once here.
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [0:0] state;
  logic [0:0] state_next;
  logic       grant_idx;
  logic       grant_idx_next;
  logic       last_grant;
  logic       last_grant_next;

  logic       busy;
  logic       any_req;
  logic       winner;
  logic       granted_stb;
  logic       timeout_hit;
  logic       release_bus;

  assign busy        = (state == ST_BUSY);
  assign any_req     = i_m0_stb | i_m1_stb;
  assign granted_stb = grant_idx ? i_m1_stb : i_m0_stb;

  // Choose who wins from IDLE: a lone requester wins, and a tie goes to whoever did not own the bus last.
  always_comb begin
    winner = 1'b0;
    if (i_m0_stb && i_m1_stb) begin
      winner = ~last_grant;
    end else if (i_m1_stb) begin
      winner = 1'b1;
    end
  end

  // A busy transaction ends on ack, on the owner dropping its strobe, or on a watchdog abort.
  assign release_bus = busy & (i_ext_ack | ~granted_stb | timeout_hit);

  // Next-state logic: the grant is latched on leaving IDLE, and last_grant is updated on every release.
  always_comb begin
    state_next      = state;
    grant_idx_next  = grant_idx;
    last_grant_next = last_grant;
    if (state == ST_IDLE) begin
      if (any_req) begin
        state_next     = ST_BUSY;
        grant_idx_next = winner;
      end
    end else begin
      if (release_bus) begin
        state_next      = ST_IDLE;
        last_grant_next = grant_idx;
      end
    end
  end

  // State registers; last_grant resets to 1 so that m0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      grant_idx  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      grant_idx  <= grant_idx_next;
      last_grant <= last_grant_next;
    end
  end

  // Forward the owner's request to the external bus, and drive the bus quiet while idle.
  always_comb begin
    o_ext_addr  = 16'h0000;
    o_ext_stb   = 1'b0;
    o_ext_we    = 4'h0;
    o_ext_dat_w = 32'h0000_0000;
    if (busy) begin
      o_ext_stb = granted_stb;
      if (grant_idx) begin
        o_ext_addr  = i_m1_addr;
        o_ext_we    = i_m1_we;
        o_ext_dat_w = i_m1_dat_w;
      end else begin
        o_ext_addr  = i_m0_addr;
        o_ext_we    = i_m0_we;
        o_ext_dat_w = i_m0_dat_w;
      end
    end
  end

  // Route the external ack to the owner only; an ack seen while idle goes nowhere.
  always_comb begin
    o_m0_ack = 1'b0;
    o_m1_ack = 1'b0;
    if (busy && i_ext_ack) begin
      if (grant_idx) begin
        o_m1_ack = 1'b1;
      end else begin
        o_m0_ack = 1'b1;
      end
    end
  end

  // Read data is broadcast; each requester qualifies it with its own ack.
  assign o_m0_dat_r = i_ext_dat_r;
  assign o_m1_dat_r = i_ext_dat_r;

  // Debug view of the current owner, one-hot, or zero while idle.
  always_comb begin
    o_grant = 2'b00;
    if (busy) begin
      o_grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

`ifdef EXT_ARB_TIMEOUT_EN
  logic [15:0] timeout_count;
  logic [15:0] timeout_count_inc;
  logic        m0_err;
  logic        m1_err;

  assign timeout_count_inc = timeout_count + 16'd1;

  // The abort fires on the unacked cycle that brings the count to the limit; an ack in that cycle takes priority.
  assign timeout_hit = busy & granted_stb & ~i_ext_ack & (timeout_count_inc == TIMEOUT_LIMIT);

  // Watchdog counter (held at zero while idle) and the one-cycle err pulse to the aborted owner.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timeout_count <= 16'd0;
      m0_err        <= 1'b0;
      m1_err        <= 1'b0;
    end else begin
      m0_err <= timeout_hit & ~grant_idx;
      m1_err <= timeout_hit & grant_idx;
      if (!busy) begin
        timeout_count <= 16'd0;
      end else if (!i_ext_ack) begin
        timeout_count <= timeout_count_inc;
      end
    end
  end

  assign o_m0_err = m0_err;
  assign o_m1_err = m1_err;
`else
  logic unused_timeout_cfg;

  // Without the watchdog a granted requester waits for its ack indefinitely.
  assign timeout_hit        = 1'b0;
  assign o_m0_err           = 1'b0;
  assign o_m1_err           = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_LIMIT;
`endif

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// tb_ext_bus_arbiter
// Self-checking bench for ext_bus_arbiter.
// It applies a hand-derived vector table, then the multi-cycle timeout and
// no-timeout sequences, then random traffic checked against a transaction-level model.
// The EXT_ARB_TIMEOUT_EN macro selects the matching expectations.
`timescale 1ns/1ps
module tb_ext_bus_arbiter;

  localparam int TO = 4;
  localparam int NVEC = 19;
  localparam int NRAND = 3000;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_m0_addr;
  logic        i_m0_stb;
  logic [3:0]  i_m0_we;
  logic [31:0] i_m0_dat_w;
  logic        o_m0_ack;
  logic [31:0] o_m0_dat_r;
  logic        o_m0_err;
  logic [15:0] i_m1_addr;
  logic        i_m1_stb;
  logic [3:0]  i_m1_we;
  logic [31:0] i_m1_dat_w;
  logic        o_m1_ack;
  logic [31:0] o_m1_dat_r;
  logic        o_m1_err;
  logic [15:0] o_ext_addr;
  logic        o_ext_stb;
  logic [3:0]  o_ext_we;
  logic [31:0] o_ext_dat_w;
  logic        i_ext_ack;
  logic [31:0] i_ext_dat_r;
  logic [1:0]  o_grant;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic       rst;
    logic       s0;
    logic       s1;
    logic       ack;
    logic       ext_stb;
    logic [1:0] grant;
    logic       ack0;
    logic       ack1;
  } vec_t;

  vec_t vecs [NVEC];

  // Reference model state, kept at transaction level
  bit m_busy;
  int m_owner;
  int m_last;
  int m_cnt;
  int m_err_owner;

  ext_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_m0_addr  (i_m0_addr),
    .i_m0_stb   (i_m0_stb),
    .i_m0_we    (i_m0_we),
    .i_m0_dat_w (i_m0_dat_w),
    .o_m0_ack   (o_m0_ack),
    .o_m0_dat_r (o_m0_dat_r),
    .o_m0_err   (o_m0_err),
    .i_m1_addr  (i_m1_addr),
    .i_m1_stb   (i_m1_stb),
    .i_m1_we    (i_m1_we),
    .i_m1_dat_w (i_m1_dat_w),
    .o_m1_ack   (o_m1_ack),
    .o_m1_dat_r (o_m1_dat_r),
    .o_m1_err   (o_m1_err),
    .o_ext_addr (o_ext_addr),
    .o_ext_stb  (o_ext_stb),
    .o_ext_we   (o_ext_we),
    .o_ext_dat_w(o_ext_dat_w),
    .i_ext_ack  (i_ext_ack),
    .i_ext_dat_r(i_ext_dat_r),
    .o_grant    (o_grant)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic s0, input logic s1, input logic ack);
    i_rst     = rst;
    i_m0_stb  = s0;
    i_m1_stb  = s1;
    i_ext_ack = ack;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_reset();
    m_busy      = 1'b0;
    m_owner     = 0;
    m_last      = 1;
    m_cnt       = 0;
    m_err_owner = -1;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    bit s [2];
    s[0] = i_m0_stb;
    s[1] = i_m1_stb;
    if (i_rst) begin
      model_reset();
    end else begin
      m_err_owner = -1;
      if (!m_busy) begin
        if (s[0] || s[1]) begin
          if (s[0] && s[1]) m_owner = 1 - m_last;
          else              m_owner = s[0] ? 0 : 1;
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end else if (i_ext_ack || !s[m_owner]) begin
        m_last = m_owner;
        m_busy = 1'b0;
      end else begin
`ifdef EXT_ARB_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == TO) begin
          m_err_owner = m_owner;
          m_last      = m_owner;
          m_busy      = 1'b0;
        end
`endif
      end
    end
  endtask

  // Compare all outputs against the model for the current cycle
  task automatic check_against_model(input int cyc);
    logic        e_stb;
    logic [15:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_dat;
    logic [1:0]  e_grant;
    e_stb   = 1'b0;
    e_addr  = 16'h0;
    e_we    = 4'h0;
    e_dat   = 32'h0;
    e_grant = 2'b00;
    if (m_busy) begin
      e_grant = 2'(1 << m_owner);
      e_stb   = (m_owner == 0) ? i_m0_stb   : i_m1_stb;
      e_addr  = (m_owner == 0) ? i_m0_addr  : i_m1_addr;
      e_we    = (m_owner == 0) ? i_m0_we    : i_m1_we;
      e_dat   = (m_owner == 0) ? i_m0_dat_w : i_m1_dat_w;
    end
    check_output($sformatf("rnd%0d grant", cyc), {30'b0, o_grant}, {30'b0, e_grant});
    check_output($sformatf("rnd%0d ext_stb", cyc), {31'b0, o_ext_stb}, {31'b0, e_stb});
    check_output($sformatf("rnd%0d ext_addr", cyc), {16'b0, o_ext_addr}, {16'b0, e_addr});
    check_output($sformatf("rnd%0d ext_we", cyc), {28'b0, o_ext_we}, {28'b0, e_we});
    check_output($sformatf("rnd%0d ext_dat_w", cyc), o_ext_dat_w, e_dat);
    check_output($sformatf("rnd%0d m0_ack", cyc), {31'b0, o_m0_ack},
                 {31'b0, (m_busy && m_owner == 0 && i_ext_ack)});
    check_output($sformatf("rnd%0d m1_ack", cyc), {31'b0, o_m1_ack},
                 {31'b0, (m_busy && m_owner == 1 && i_ext_ack)});
    check_output($sformatf("rnd%0d m0_err", cyc), {31'b0, o_m0_err}, {31'b0, (m_err_owner == 0)});
    check_output($sformatf("rnd%0d m1_err", cyc), {31'b0, o_m1_err}, {31'b0, (m_err_owner == 1)});
    check_output($sformatf("rnd%0d m0_dat_r", cyc), o_m0_dat_r, i_ext_dat_r);
    check_output($sformatf("rnd%0d m1_dat_r", cyc), o_m1_dat_r, i_ext_dat_r);
  endtask

  initial begin
    // Fixed payloads for the directed part
    i_m0_addr   = 16'h0010;
    i_m0_we     = 4'hF;
    i_m0_dat_w  = 32'hDEADBEEF;
    i_m1_addr   = 16'h0020;
    i_m1_we     = 4'h0;
    i_m1_dat_w  = 32'hCAFE0001;
    i_ext_dat_r = 32'h12345678;

    //                rst   s0    s1    ack   ext_stb grant  ack0  ack1
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();

    // Directed table: one row per clock cycle
    for (int i = 0; i < NVEC; i++) begin
      logic [15:0] e_addr;
      logic [3:0]  e_we;
      logic [31:0] e_dat;
      apply_stimulus(vecs[i].rst, vecs[i].s0, vecs[i].s1, vecs[i].ack);
      @(negedge i_clk);
      e_addr = 16'h0;
      e_we   = 4'h0;
      e_dat  = 32'h0;
      if (vecs[i].grant == 2'b01) begin
        e_addr = 16'h0010;
        e_we   = 4'hF;
        e_dat  = 32'hDEADBEEF;
      end else if (vecs[i].grant == 2'b10) begin
        e_addr = 16'h0020;
        e_we   = 4'h0;
        e_dat  = 32'hCAFE0001;
      end
      check_output($sformatf("vec%0d ext_stb", i), {31'b0, o_ext_stb}, {31'b0, vecs[i].ext_stb});
      check_output($sformatf("vec%0d grant", i), {30'b0, o_grant}, {30'b0, vecs[i].grant});
      check_output($sformatf("vec%0d m0_ack", i), {31'b0, o_m0_ack}, {31'b0, vecs[i].ack0});
      check_output($sformatf("vec%0d m1_ack", i), {31'b0, o_m1_ack}, {31'b0, vecs[i].ack1});
      check_output($sformatf("vec%0d ext_addr", i), {16'b0, o_ext_addr}, {16'b0, e_addr});
      check_output($sformatf("vec%0d ext_we", i), {28'b0, o_ext_we}, {28'b0, e_we});
      check_output($sformatf("vec%0d ext_dat_w", i), o_ext_dat_w, e_dat);
      check_output($sformatf("vec%0d m0_dat_r", i), o_m0_dat_r, 32'h12345678);
      check_output($sformatf("vec%0d m1_dat_r", i), o_m1_dat_r, 32'h12345678);
      next_cycle();
    end

    // Contention right after reset with no ack from the external bus
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge i_clk);
    check_output("seq arb grant", {30'b0, o_grant}, 32'd0);
    next_cycle();
`ifdef EXT_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      @(negedge i_clk);
      check_output($sformatf("to m0 busy%0d grant", k), {30'b0, o_grant}, 32'd1);
      check_output($sformatf("to m0 busy%0d err", k), {31'b0, o_m0_err}, 32'd0);
      next_cycle();
    end
    @(negedge i_clk);
    check_output("to m0 err pulse", {31'b0, o_m0_err}, 32'd1);
    check_output("to m1 err quiet", {31'b0, o_m1_err}, 32'd0);
    check_output("to ext_stb dropped", {31'b0, o_ext_stb}, 32'd0);
    check_output("to grant idle", {30'b0, o_grant}, 32'd0);
    next_cycle();
    for (int k = 1; k <= TO - 1; k++) begin
      @(negedge i_clk);
      check_output($sformatf("to m1 busy%0d grant", k), {30'b0, o_grant}, 32'd2);
      check_output($sformatf("to m0 err cleared%0d", k), {31'b0, o_m0_err}, 32'd0);
      next_cycle();
    end
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge i_clk);
    check_output("to race m1 ack", {31'b0, o_m1_ack}, 32'd1);
    check_output("to race m0 ack", {31'b0, o_m0_ack}, 32'd0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    check_output("to race m1 err", {31'b0, o_m1_err}, 32'd0);
    check_output("to race grant idle", {30'b0, o_grant}, 32'd0);
    next_cycle();
`else
    for (int k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      check_output($sformatf("wait%0d grant", k), {30'b0, o_grant}, 32'd1);
      check_output($sformatf("wait%0d ext_stb", k), {31'b0, o_ext_stb}, 32'd1);
      check_output($sformatf("wait%0d m0_err", k), {31'b0, o_m0_err}, 32'd0);
      next_cycle();
    end
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge i_clk);
    check_output("wait final m0 ack", {31'b0, o_m0_ack}, 32'd1);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    check_output("wait final grant", {30'b0, o_grant}, 32'd0);
    next_cycle();
`endif

    // Random traffic against the reference model
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    model_reset();
    for (int c = 0; c < NRAND; c++) begin
      i_rst       = ($urandom_range(0, 99) == 0);
      i_m0_stb    = ($urandom_range(0, 4) == 0) ? ~i_m0_stb : i_m0_stb;
      i_m1_stb    = ($urandom_range(0, 4) == 0) ? ~i_m1_stb : i_m1_stb;
      i_ext_ack   = ($urandom_range(0, 3) == 0);
      i_m0_addr   = 16'($urandom);
      i_m1_addr   = 16'($urandom);
      i_m0_we     = 4'($urandom);
      i_m1_we     = 4'($urandom);
      i_m0_dat_w  = $urandom;
      i_m1_dat_w  = $urandom;
      i_ext_dat_r = $urandom;
      @(negedge i_clk);
      check_against_model(c);
      model_step();
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
